mmio_timer: RTL and testbench

Memory-mapped down-counting timer on the single-cycle MIPS core's data-memory bus, downstream of the core alongside data memory. Decodes the core's data address, takes word stores to its four registers, and returns read data for the load-result mux. Gives software a programmable periodic/one-shot timebase with a sticky expiry flag and a level interrupt.

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_timer_tick_gen.sv | 45 ++++
 rtl/mmio_timer.sv | 133 +++++++++++++
 tb/tb_mmio_timer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg
//   Shared definitions for the memory-mapped timer: register word offsets
//   inside the 16-byte window, CTRL bit positions, the default window base
//   and the count-FSM state type.
package mmio_pkg;

   // Register word offsets (memaddr[3:2])
   localparam logic [1:0] CTRL_OFS   = 2'd0;
   localparam logic [1:0] LOAD_OFS   = 2'd1;
   localparam logic [1:0] COUNT_OFS  = 2'd2;
   localparam logic [1:0] STATUS_OFS = 2'd3;

   // CTRL bit positions
   localparam int EN_BIT    = 0;
   localparam int AR_BIT    = 1;
   localparam int IRQEN_BIT = 2;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

   // The count FSM has no register of its own: its state is CTRL.en.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } cnt_state_e;

   // Zero-extend the 3-bit CTRL register to a bus word.
   function automatic logic [31:0] ctrl_word(input logic [2:0] ctrl);
      return {29'd0, ctrl};
   endfunction

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// tick_gen
//   Prescaler for mmio_timer. Counts 0..PRESCALE-1 while run=1 and
//   emits a one-cycle tick in the cycle where the counter wraps.
//   Holds at 0 while run=0 and restarts at 0 whenever restart=1.
// Ports:
//   clk      in   core clock, rising edge
//   reset    in   asynchronous, active-low
//   run      in   prescaler enabled (CTRL.en)
//   restart  in   CTRL is being written this cycle
//   tick     out  one-cycle count tick (combinational from the counter)
module tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic restart,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt_q, cnt_d;
   logic        wrap;

   assign wrap = (cnt_q == LAST);
   // A CTRL write in the same cycle discards the tick.
   assign tick = run & ~restart & wrap;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (restart || !run || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer
//   Down-counting timer on the MIPS core's data bus. Decodes a 16-byte
//   register window (CTRL, LOAD, COUNT, STATUS), accepts word stores,
//   returns combinational read data and raises a level interrupt when the
//   sticky expiry flag is set and interrupts are enabled.
// Ports:
//   clk           in   core clock, rising edge
//   reset         in   asynchronous, active-low
//   memaddr       in   core data address
//   memwrite      in   core store strobe
//   memwritedata  in   core store data
//   sel           out  address hits the register window (combinational)
//   rdata         out  read data of the addressed register (combinational)
//   irq           out  STATUS.expired & CTRL.irqen
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memaddr,
   input  logic        memwrite,
   input  logic [31:0] memwritedata,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [1:0]  idx;
   logic        wr, wr_ctrl, wr_load, wr_count, wr_status;
   logic        tick, expire;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        expired_q, expired_d;
   cnt_state_e  state;
   logic        unused_addr_bits;

   // Byte offset bits are ignored: word access only.
   assign unused_addr_bits = ^memaddr[1:0];

   assign sel       = (memaddr[31:4] == BASE_ADDR[31:4]);
   assign idx       = memaddr[3:2];
   assign wr        = sel & memwrite;
   assign wr_ctrl   = wr && (idx == CTRL_OFS);
   assign wr_load   = wr && (idx == LOAD_OFS);
   assign wr_count  = wr && (idx == COUNT_OFS);
   assign wr_status = wr && (idx == STATUS_OFS);

   assign state = cnt_state_e'(ctrl_q[EN_BIT]);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .run     (ctrl_q[EN_BIT]),
      .restart (wr_ctrl),
      .tick    (tick)
   );

   // Next-state: count FSM first, then software writes override it.
   always_comb begin
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      expire  = 1'b0;

      case (state)
         ST_IDLE: begin
            // Only a CTRL write with en=1 (applied below) starts counting.
         end
         ST_RUN: begin
            // A COUNT or CTRL store in the tick cycle discards the tick.
            if (tick && !wr_count && !wr_ctrl) begin
               if (count_q != 32'd0) begin
                  count_d = count_q - 32'd1;
               end else begin
                  expire = 1'b1;
                  if (ctrl_q[AR_BIT]) begin
                     // Uses the LOAD value from before any same-cycle store.
                     count_d = load_q;
                  end else begin
                     ctrl_d[EN_BIT] = 1'b0;
                  end
               end
            end
         end
      endcase

      // Expiry beats a same-cycle write-1-to-clear.
      expired_d = expire | (expired_q & ~(wr_status & memwritedata[0]));

      if (wr_ctrl) begin
         ctrl_d = memwritedata[2:0];
      end
      if (wr_load) begin
         load_d = memwritedata;
      end
      if (wr_count) begin
         count_d = memwritedata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (idx)
         CTRL_OFS:   rdata = ctrl_word(ctrl_q);
         LOAD_OFS:   rdata = load_q;
         COUNT_OFS:  rdata = count_q;
         STATUS_OFS: rdata = {31'd0, expired_q};
      endcase
   end

   assign irq = expired_q & ctrl_q[IRQEN_BIT];

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
//   Two timer instances (PRESCALE=1 and PRESCALE=4) share one bus. Directed
//   steps followed by random stores; every register of both instances is
//   compared against a per-edge behavioural model after each clock edge.
module tb_mmio_timer;
   import mmio_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] memaddr = BASE;
   logic        memwrite = 1'b0;
   logic [31:0] memwritedata = 32'd0;
   logic        sel1, sel4, irq1, irq4;
   logic [31:0] rdata1, rdata4;
   logic        last_sel1, last_sel4;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
   bit          m_en[2], m_ar[2], m_ie[2], m_exp[2];
   logic [31:0] m_load[2], m_count[2];
   int          m_el[2];   // cycles elapsed since counting (re)started

   always #10 clk = ~clk;

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(rst_n), .memaddr(memaddr), .memwrite(memwrite),
      .memwritedata(memwritedata), .sel(sel1), .rdata(rdata1), .irq(irq1));

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
      .clk(clk), .reset(rst_n), .memaddr(memaddr), .memwrite(memwrite),
      .memwritedata(memwritedata), .sel(sel4), .rdata(rdata4), .irq(irq4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_en[d] = 0; m_ar[d] = 0; m_ie[d] = 0; m_exp[d] = 0;
         m_load[d] = 0; m_count[d] = 0; m_el[d] = 0;
      end
   endtask

   function automatic logic [31:0] model_reg(input int d, input logic [1:0] r);
      case (r)
         2'd0:    return {29'd0, m_ie[d], m_ar[d], m_en[d]};
         2'd1:    return m_load[d];
         2'd2:    return m_count[d];
         default: return {31'd0, m_exp[d]};
      endcase
   endfunction

   // One clock edge of the timer as software sees it.
   task automatic model_edge(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] data);
      int         p;
      logic       hit;
      logic [1:0] r;
      bit         cw, lw, nw, sw, tick, en_n;
      p    = (d == 1) ? 4 : 1;
      hit  = (a[31:4] == BASE[31:4]);
      r    = a[3:2];
      cw   = w && hit && (r == 2'd0);
      lw   = w && hit && (r == 2'd1);
      nw   = w && hit && (r == 2'd2);
      sw   = w && hit && (r == 2'd3);
      tick = m_en[d] && (((m_el[d] + 1) % p) == 0) && !cw && !nw;
      en_n = m_en[d];
      if (sw && data[0]) m_exp[d] = 0;
      if (tick) begin
         if (m_count[d] != 0) begin
            m_count[d] = m_count[d] - 1;
         end else begin
            m_exp[d] = 1;
            if (m_ar[d]) m_count[d] = m_load[d];
            else en_n = 0;
         end
      end
      if (lw) m_load[d] = data;
      if (nw) m_count[d] = data;
      if (cw) begin
         en_n = data[0]; m_ar[d] = data[1]; m_ie[d] = data[2];
      end
      m_el[d] = (cw || !en_n) ? 0 : (m_en[d] ? m_el[d] + 1 : 0);
      m_en[d] = en_n;
   endtask

   // Drive one bus cycle from the falling edge, capture sel before the
   // rising edge, advance the model after it.
   task automatic step(input logic w, input logic [31:0] a, input logic [31:0] data);
      @(negedge clk);
      memwrite = w; memaddr = a; memwritedata = data;
      #1;
      last_sel1 = sel1; last_sel4 = sel4;
      if (w) $display("[%0t] wr addr=%h data=%h", $time, a, data);
      @(posedge clk);
      #1;
      if (rst_n) begin
         model_edge(0, w, a, data);
         model_edge(1, w, a, data);
      end
      memwrite = 1'b0;
   endtask

   task automatic wr(input logic [1:0] ofs, input logic [31:0] data);
      step(1'b1, BASE + {28'd0, ofs, 2'b00}, data);
   endtask

   task automatic idle();
      step(1'b0, BASE, 32'd0);
   endtask

   task automatic rd_chk(input string tag, input int d, input logic [1:0] r,
                         input logic [31:0] exp);
      memaddr = BASE + {28'd0, r, 2'b00};
      #1;
      chk(tag, (d == 1) ? rdata4 : rdata1, exp);
   endtask

   task automatic check_all();
      for (int r = 0; r < 4; r++) begin
         memaddr = BASE + 32'(r * 4);
         #1;
         chk($sformatf("rd_p1_r%0d", r), rdata1, model_reg(0, 2'(r)));
         chk($sformatf("rd_p4_r%0d", r), rdata4, model_reg(1, 2'(r)));
      end
      chk("sel_p1", 32'(sel1), 32'd1);
      chk("irq_p1", 32'(irq1), 32'(m_exp[0] & m_ie[0]));
      chk("irq_p4", 32'(irq4), 32'(m_exp[1] & m_ie[1]));
   endtask

   initial begin
      logic [1:0]  r;
      logic        w;
      logic [31:0] a, data;

      // Reset state
      model_reset();
      repeat (3) idle();
      check_all();
      rst_n = 1'b1;

      // Reset in the middle of counting, checked before any clock edge
      wr(COUNT_OFS, 32'd100);
      wr(CTRL_OFS, 32'd1);
      repeat (10) idle();
      rd_chk("pre_reset_count", 0, COUNT_OFS, 32'd90);
      rst_n = 1'b0;
      model_reset();
      check_all();
      idle();
      rst_n = 1'b1;

      // One-shot on the PRESCALE=1 instance
      wr(COUNT_OFS, 32'd3);
      wr(CTRL_OFS, 32'd5);
      for (int k = 1; k <= 4; k++) begin
         idle();
         rd_chk("oneshot_exp", 0, STATUS_OFS, 32'(k == 4));
         chk("oneshot_irq", 32'(irq1), 32'(k == 4));
      end
      check_all();
      rd_chk("oneshot_count", 0, COUNT_OFS, 32'd0);
      rd_chk("oneshot_ctrl", 0, CTRL_OFS, 32'd4);
      wr(CTRL_OFS, 32'd0);
      wr(STATUS_OFS, 32'd1);
      check_all();

      // Autoreload on the PRESCALE=4 instance: period (2+1)*4 = 12
      wr(LOAD_OFS, 32'd2);
      wr(COUNT_OFS, 32'd2);
      wr(CTRL_OFS, 32'd3);
      for (int k = 1; k <= 24; k++) begin
         if (k == 14) wr(STATUS_OFS, 32'd1);
         else idle();
         check_all();
         if (k == 11 || k == 12 || k == 14 || k == 23 || k == 24)
            rd_chk($sformatf("autoreload_exp_k%0d", k), 1, STATUS_OFS,
                   32'(k == 12 || k == 24));
      end

      // Collisions on the PRESCALE=1 instance (ticks every cycle)
      wr(COUNT_OFS, 32'h50);
      rd_chk("coll_count_write", 0, COUNT_OFS, 32'h50);
      check_all();
      wr(STATUS_OFS, 32'd1);
      rd_chk("status_cleared", 0, STATUS_OFS, 32'd0);
      wr(COUNT_OFS, 32'd0);
      wr(STATUS_OFS, 32'd1);
      rd_chk("coll_status_clear", 0, STATUS_OFS, 32'd1);
      rd_chk("coll_reload", 0, COUNT_OFS, 32'd2);
      idle();
      idle();
      wr(LOAD_OFS, 32'd9);
      rd_chk("coll_load_old", 0, COUNT_OFS, 32'd2);
      repeat (3) idle();
      rd_chk("coll_load_new", 0, COUNT_OFS, 32'd9);
      check_all();

      // Address decode
      wr(CTRL_OFS, 32'd0);
      wr(COUNT_OFS, 32'h1234);
      check_all();
      step(1'b1, BASE + 32'h10, 32'hFFFF_FFFF);
      chk("sel_above", 32'(last_sel1), 32'd0);
      step(1'b1, BASE - 32'd4, 32'hFFFF_FFFF);
      chk("sel_below", 32'(last_sel4), 32'd0);
      check_all();
      rd_chk("decode_ctrl", 0, CTRL_OFS, 32'd0);
      memaddr = BASE + 32'h9;
      #1;
      chk("unaligned_count", rdata1, 32'h1234);
      chk("unaligned_sel", 32'(sel1), 32'd1);

      // Write-0 to STATUS and CTRL bit masking
      wr(STATUS_OFS, 32'd0);
      rd_chk("status_w0", 0, STATUS_OFS, 32'd1);
      wr(CTRL_OFS, 32'hFFFF_FFFF);
      rd_chk("ctrl_mask_p1", 0, CTRL_OFS, 32'd7);
      rd_chk("ctrl_mask_p4", 1, CTRL_OFS, 32'd7);
      check_all();

      // Random stores against the model
      for (int i = 0; i < 400; i++) begin
         r = 2'($urandom_range(0, 3));
         w = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 15) == 0)
            a = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 + {28'd0, r, 2'b00}
                                             : BASE - 32'h10 + {28'd0, r, 2'b00};
         else
            a = BASE + {28'd0, r, 2'b00} + 32'($urandom_range(0, 3));
         if (r == LOAD_OFS || r == COUNT_OFS) data = 32'($urandom_range(0, 6));
         else data = $urandom;
         step(w, a, data);
         check_all();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
